// File: rtl/toggle_cond_pkg.sv
// Shared types and defaults for the push-button conditioner that feeds the T flip-flop.
// Holds the qualification FSM encoding and the default timing constants.
package toggle_cond_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } tcond_state_e;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 50000;

   // True while a candidate level change is still being qualified.
   function automatic logic is_wait(tcond_state_e st);
      return (st == WAIT_HIGH) || (st == WAIT_LOW);
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous level input; the last stage is the only safe tap.
// Reused for any other asynchronous panel inputs.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
      end
   end

   assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_button_conditioner.sv
// Synchronises and debounces a raw push button, emitting one toggle pulse per accepted press
// and one release pulse per accepted release, plus the debounced level.
module toggle_button_conditioner
   import toggle_cond_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_WIDTH     = 16
) (
   input  logic input_clock,
   input  logic input_reset,
   input  logic input_button,
   output logic output_toggle,
   output logic output_release,
   output logic output_level,
   output logic output_busy
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("toggle_button_conditioner: SYNC_STAGES must be 2 or more");
   end
   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("toggle_button_conditioner: STABLE_CYCLES must be 1 or more");
   end
   if (CNT_WIDTH < 1 || CNT_WIDTH < $clog2(STABLE_CYCLES)) begin : g_bad_cnt
      $error("toggle_button_conditioner: CNT_WIDTH cannot reach STABLE_CYCLES-1");
   end

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic                 btn_sync;
   tcond_state_e         state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 level_q, level_d;
   logic                 toggle_q, toggle_d;
   logic                 release_q, release_d;

   sync_chain #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i  (input_clock),
      .rst_i  (input_reset),
      .async_i(input_button),
      .sync_o (btn_sync)
   );

   always_ff @(posedge input_clock or posedge input_reset) begin
      if (input_reset) begin
         state_q   <= IDLE_LOW;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         toggle_q  <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         toggle_q  <= toggle_d;
         release_q <= release_d;
      end
   end

   // The counter saturates at CNT_LAST by construction: reaching it always leaves the WAIT state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      toggle_d  = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (btn_sync) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!btn_sync) begin
               state_d = IDLE_LOW;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = IDLE_HIGH;
               level_d  = 1'b1;
               toggle_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         IDLE_HIGH: begin
            if (!btn_sync) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
            end
         end
         WAIT_LOW: begin
            if (btn_sync) begin
               state_d = IDLE_HIGH;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE_LOW;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign output_toggle  = toggle_q;
   assign output_release = release_q;
   assign output_level   = level_q;
   assign output_busy    = is_wait(state_q);

endmodule

// File: tb/tb_toggle_button_conditioner.sv
// Bench for toggle_button_conditioner with SYNC_STAGES=2, STABLE_CYCLES=4, CNT_WIDTH=3.
// A run-length reference model checks every cycle; directed tables and sequences cover the corners.
module tb_toggle_button_conditioner;

   localparam int SYNC   = 2;
   localparam int STABLE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b0;
   logic out_toggle, out_release, out_level, out_busy;

   always #5 clk = ~clk;

   toggle_button_conditioner #(
      .SYNC_STAGES  (SYNC),
      .STABLE_CYCLES(STABLE),
      .CNT_WIDTH    (3)
   ) dut (
      .input_clock   (clk),
      .input_reset   (rst),
      .input_button  (btn),
      .output_toggle (out_toggle),
      .output_release(out_release),
      .output_level  (out_level),
      .output_busy   (out_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int tog_cnt, rel_cnt, busy_cnt, last_tog_edge;

   // Reference: the FSM input lags the raw button by SYNC edges; a level change is accepted
   // once the FSM has seen the new level on STABLE+1 consecutive edges.
   logic m_pipe[$];
   logic m_level, m_tog, m_rel;
   int   m_run;

   function automatic logic [3:0] model_vec();
      return {m_tog, m_rel, m_level, (m_run != 0)};
   endfunction

   task automatic model_reset();
      m_pipe.delete();
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
      m_level = 1'b0;
      m_tog   = 1'b0;
      m_rel   = 1'b0;
      m_run   = 0;
   endtask

   task automatic model_edge(input logic b);
      logic s;
      s = m_pipe.pop_front();
      m_pipe.push_back(b);
      m_tog = 1'b0;
      m_rel = 1'b0;
      if (s != m_level) begin
         m_run++;
         if (m_run == STABLE + 1) begin
            m_level = s;
            m_run   = 0;
            if (s) m_tog = 1'b1;
            else   m_rel = 1'b1;
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got {tog,rel,lvl,busy}=%b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0] dut_vec();
      return {out_toggle, out_release, out_level, out_busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else model_edge(btn);
      @(negedge clk);
      if (out_toggle) begin
         tog_cnt++;
         last_tog_edge = cyc;
      end
      if (out_release) rel_cnt++;
      if (out_busy) busy_cnt++;
      check4("model", dut_vec(), model_vec());
   endtask

   task automatic clear_counts();
      tog_cnt       = 0;
      rel_cnt       = 0;
      busy_cnt      = 0;
      last_tog_edge = -1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn = 1'b0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      clear_counts();
   endtask

   typedef struct {
      logic       button;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[17];

   initial begin
      int n0;
      logic [3:0] tbl_exp[17];
      tbl_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1010, 4'b0010,
                  4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0100,
                  4'b0000};
      for (int i = 0; i < 17; i++) begin
         vecs[i].button = (i < 9);
         vecs[i].exp    = tbl_exp[i];
      end
      model_reset();
      clear_counts();

      // Reset state, then clean press followed by clean release.
      do_reset();
      check4("reset_state", dut_vec(), 4'b0000);
      for (int i = 0; i < 17; i++) begin
         btn = vecs[i].button;
         tick();
         check4($sformatf("table[%0d]", i), dut_vec(), vecs[i].exp);
      end

      // Bounce 1,0,1,0 then steady 1: one toggle, six edges after the final rise's first edge.
      do_reset();
      btn = 1'b1; tick();
      btn = 1'b0; tick();
      btn = 1'b1; tick();
      btn = 1'b0; tick();
      btn = 1'b1;
      n0 = cyc + 1;
      for (int i = 0; i < 12; i++) tick();
      check_int("bounce_toggles", tog_cnt, 1);
      check_int("bounce_latency", last_tog_edge, n0 + 6);

      // Glitch shorter than qualification.
      do_reset();
      btn = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      btn = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check_int("glitch_toggles", tog_cnt, 0);
      check_int("glitch_busy_seen", int'(busy_cnt > 0), 1);
      check4("glitch_final", dut_vec(), 4'b0000);

      // Long hold: one toggle only, then one release.
      do_reset();
      btn = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      check_int("hold_toggles", tog_cnt, 1);
      check4("hold_level", dut_vec(), 4'b0010);
      btn = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check_int("hold_releases", rel_cnt, 1);
      check_int("hold_toggles_after_release", tog_cnt, 1);

      // Asynchronous reset between edges 5 and 6 of a held press.
      do_reset();
      btn = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check4("midq_busy", dut_vec(), 4'b0001);
      #2 rst = 1'b1;
      model_reset();
      #1 check4("midq_async_clear", dut_vec(), 4'b0000);
      #1 rst = 1'b0;
      clear_counts();
      n0 = cyc + 1;
      for (int i = 0; i < 10; i++) tick();
      check_int("midq_toggles", tog_cnt, 1);
      check_int("midq_latency", last_tog_edge, n0 + 6);

      // Random hold lengths around the qualification window.
      do_reset();
      for (int seg = 0; seg < 80; seg++) begin
         int hold;
         btn  = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 9);
         for (int i = 0; i < hold; i++) tick();
      end
      btn = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check_int("random_balanced", tog_cnt, rel_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
